// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: producer request bus plus the FIFO write/status port shared through the arbiter.
// Latency: none, signal bundle only.
// Backpressure: carried by ack (producers) and lleno/use_dw (FIFO).
interface fifo_wr_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int DEPTH = 32,
  parameter int WIDTH = 8
);
  localparam int ADDRESS = $clog2(DEPTH-1);
  localparam int IDW     = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       ack;
  logic                  lleno;
  logic [ADDRESS-1:0]    use_dw;
  logic                  wr_en;
  logic [WIDTH-1:0]      data_in;
  logic [IDW-1:0]        grant_id;

  // Arbiter side
  modport master (
    input  req, req_data, lleno, use_dw,
    output ack, wr_en, data_in, grant_id
  );

  // Producers + FIFO side
  modport slave (
    output req, req_data, lleno, use_dw,
    input  ack, wr_en, data_in, grant_id
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-bounded sharing of one synchronous FIFO write port among NREQ producers.
// Latency: ack is combinational; the acked word is on wr_en/data_in in the following cycle, 1 word/cycle.
// Backpressure: no ack while lleno or (use_dw + in-flight wr_en) > DEPTH-2; producers hold req/data until ack.
// Optional macro FIFO_ARB_STALL_CNT_EN adds a 16-bit saturating stall_cnt output.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DEPTH     = 32,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst,
  fifo_wr_arbiter_if.master  bus
`ifdef FIFO_ARB_STALL_CNT_EN
  ,
  output logic [15:0]        stall_cnt
`endif
);

  localparam int ADDRESS = $clog2(DEPTH-1);
  localparam int IDW     = $clog2(NREQ);
  localparam int CW      = $clog2(MAX_BURST+1);
  localparam logic [ADDRESS:0] SPACE_LIMIT = (ADDRESS+1)'(DEPTH-2);
  localparam logic [CW-1:0]    CNT_MAX     = CW'(MAX_BURST);

  typedef enum logic {IDLE, BURST} state_t;

  state_t         state;
  logic [IDW-1:0] last;       // most recent grantee; doubles as the owner while in BURST
  logic [CW-1:0]  burst_cnt;

  logic           space_ok;
  logic           rr_found;
  logic [IDW-1:0] rr_idx;
  logic           grant_vld;
  logic [IDW-1:0] grant_idx;
  logic           grant_restart;  // burst count restarts at 1 for this grant

  // Room check counts the word on wr_en, which use_dw does not yet reflect.
  always_comb begin
    space_ok = !bus.lleno &&
               (({1'b0, bus.use_dw} + {{ADDRESS{1'b0}}, bus.wr_en}) <= SPACE_LIMIT);
  end

  // Round-robin scan starting just after last; in BURST the owner is left out of the scan.
  always_comb begin : rr_scan
    int c;
    c        = 0;
    rr_found = 1'b0;
    rr_idx   = last;
    for (int k = NREQ; k >= 1; k--) begin
      c = (int'(last) + k) % NREQ;
      if (bus.req[IDW'(c)] && !(state == BURST && k == NREQ)) begin
        rr_found = 1'b1;
        rr_idx   = IDW'(c);
      end
    end
  end

  // Decide this cycle's grant: continue the burst, rotate, regrant the lone owner, or nothing.
  always_comb begin
    grant_vld     = 1'b0;
    grant_idx     = last;
    grant_restart = 1'b1;
    if (space_ok) begin
      if (state == BURST && bus.req[last] && burst_cnt < CNT_MAX) begin
        grant_vld     = 1'b1;
        grant_idx     = last;
        grant_restart = 1'b0;
      end else if (rr_found) begin
        grant_vld = 1'b1;
        grant_idx = rr_idx;
      end else if (state == BURST && bus.req[last]) begin
        grant_vld = 1'b1;
        grant_idx = last;
      end
    end
  end

  // One-hot ack, held low while reset is asserted.
  always_comb begin
    bus.ack = '0;
    if (grant_vld && rst) bus.ack[grant_idx] = 1'b1;
  end

  // FSM and registered FIFO write port; throttled cycles hold all arbitration state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      last         <= IDW'(NREQ-1);
      burst_cnt    <= '0;
      bus.wr_en    <= 1'b0;
      bus.data_in  <= '0;
      bus.grant_id <= '0;
    end else begin
      bus.wr_en <= grant_vld;
      if (grant_vld) begin
        state        <= BURST;
        last         <= grant_idx;
        burst_cnt    <= grant_restart ? CW'(1) : burst_cnt + 1'b1;
        bus.data_in  <= bus.req_data[grant_idx*WIDTH +: WIDTH];
        bus.grant_id <= grant_idx;
      end else if (space_ok) begin
        // Nobody requesting with room available: fall back to IDLE.
        state     <= IDLE;
        burst_cnt <= '0;
      end
    end
  end

`ifdef FIFO_ARB_STALL_CNT_EN
  // Count cycles where a producer is waiting only because the FIFO has no room; saturates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (|bus.req && !space_ok && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: producers and FIFO occupancy around fifo_wr_arbiter with a reference arbiter model.
// Latency: expected writes are queued at ack and compared one cycle later on wr_en/data_in/grant_id.
// Backpressure: driven through use_dw/lleno, directly or from a fill-only FIFO occupancy model.
module tb_fifo_wr_arbiter;
  localparam int NREQ = 4, DEPTH = 32, WIDTH = 8, MAX_BURST = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NREQ(NREQ), .DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

`ifdef FIFO_ARB_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  fifo_wr_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH), .WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FIFO_ARB_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  typedef struct {int id; int dat;} exp_t;
  exp_t sb[$];

  int total = 0, bad = 0;
  int m_last, m_cnt, obs_idx, occ, max_occ;
  bit m_busy, exp_wr, auto_fifo;
  int seq [NREQ];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_busy = 1'b0;
    m_last = NREQ-1;
    m_cnt  = 0;
    exp_wr = 1'b0;
    sb.delete();
  endtask

  task automatic drive_data();
    for (int i = 0; i < NREQ; i++) bus.req_data[i*WIDTH +: WIDTH] = 8'(i*64 + (seq[i] % 64));
  endtask

  // Reference arbiter: which requester should be acked this cycle (-1 for none).
  function automatic int m_pick(input logic [NREQ-1:0] r, input bit sok);
    int c;
    if (!sok) return -1;
    if (m_busy && r[m_last[1:0]] && m_cnt < MAX_BURST) return m_last;
    for (int k = 1; k <= NREQ; k++) begin
      c = (m_last + k) % NREQ;
      if (r[c[1:0]] && !(m_busy && c == m_last)) return c;
    end
    if (m_busy && r[m_last[1:0]]) return m_last;
    return -1;
  endfunction

  // One clock: check outputs of the last edge, check ack, advance model, then producers/FIFO after the edge.
  task automatic step();
    int g;
    bit sok, wrote;
    exp_t e;
    logic [NREQ-1:0] ea;
    @(negedge clk);
    wrote = bus.wr_en;
    if (exp_wr) begin
      chk("wr_en", 32'(bus.wr_en), 1);
      e = sb.pop_front();
      chk("grant_id", 32'(bus.grant_id), e.id);
      chk("data_in", 32'(bus.data_in), e.dat);
    end else begin
      chk("wr_en_idle", 32'(bus.wr_en), 0);
    end
    sok = !bus.lleno && (int'(bus.use_dw) + int'(exp_wr) <= DEPTH-2);
    g = m_pick(bus.req, sok);
    ea = '0;
    if (g >= 0) ea[g[1:0]] = 1'b1;
    chk("ack", 32'(bus.ack), 32'(ea));
    obs_idx = -1;
    for (int i = 0; i < NREQ; i++) if (bus.ack[i]) obs_idx = i;
    if (g >= 0) begin
      if (m_busy && g == m_last && m_cnt < MAX_BURST) m_cnt++;
      else m_cnt = 1;
      m_busy = 1'b1;
      m_last = g;
      sb.push_back('{g, int'(bus.req_data[g*WIDTH +: WIDTH])});
    end else if (sok) begin
      m_busy = 1'b0;
    end
    exp_wr = (g >= 0);
    @(posedge clk);
    #1;
    if (obs_idx >= 0) seq[obs_idx]++;
    drive_data();
    if (auto_fifo) begin
      if (wrote) occ++;
      if (occ > max_occ) max_occ = occ;
      bus.use_dw = 5'(occ);
      bus.lleno  = (occ >= DEPTH);
    end
  endtask

  initial begin
    rst        = 1'b0;
    bus.req    = 4'b1111;
    bus.lleno  = 1'b0;
    bus.use_dw = '0;
    auto_fifo  = 1'b0;
    occ        = 0;
    max_occ    = 0;
    for (int i = 0; i < NREQ; i++) seq[i] = 0;
    drive_data();
    m_reset();

    // Reset values, ack suppressed while in reset.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", 32'(bus.ack), 0);
    chk("rst_wr_en", 32'(bus.wr_en), 0);
    chk("rst_data_in", 32'(bus.data_in), 0);
    chk("rst_grant_id", 32'(bus.grant_id), 0);
    @(posedge clk);
    #1 rst = 1'b1;

    // All requesting, empty FIFO: bursts of four in rotation starting at 0.
    for (int k = 0; k < 17; k++) begin
      step();
      chk("rr_order", obs_idx, (k / 4) % 4);
    end

    // Single requester keeps getting regranted across burst boundaries.
    bus.req = 4'b0100;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("solo_2", obs_idx, 2);
    end

    // Owner 1 drops while 3 waits: handoff without an idle cycle.
    bus.req = 4'b0000; step(); chk("idle", obs_idx, -1);
    bus.req = 4'b0010; step(); chk("own1_a", obs_idx, 1);
    bus.req = 4'b1010; step(); chk("own1_b", obs_idx, 1);
    bus.req = 4'b1000; step(); chk("drop_to_3", obs_idx, 3);

    // Occupancy throttling boundaries.
    bus.req = 4'b0001; step(); chk("thr_pre", obs_idx, 0);
    bus.use_dw = 5'd30; step(); chk("thr30_inflight", obs_idx, -1);
    bus.use_dw = 5'd29; step(); chk("resume29", obs_idx, 0);
    bus.use_dw = 5'd0; bus.lleno = 1'b1; step(); chk("lleno", obs_idx, -1);
    bus.lleno = 1'b0; bus.use_dw = 5'd30; step(); chk("edge30_idle", obs_idx, 0);
    bus.use_dw = 5'd0;

    // Fill with no reads: occupancy must stop short of overflowing.
    auto_fifo = 1'b1;
    occ = 0;
    max_occ = 0;
    bus.req = 4'b1111;
    for (int k = 0; k < 50; k++) step();
    chk("fill_occ", occ, DEPTH-1);
    chk("fill_max", max_occ, DEPTH-1);
    auto_fifo = 1'b0;
    bus.use_dw = 5'd0;
    bus.lleno = 1'b0;

    // Reset mid-burst of owner 1: outputs clear asynchronously, requester 0 first afterwards.
    bus.req = 4'b0010;
    step();
    step();
    chk("burst1", obs_idx, 1);
    #1 rst = 1'b0;
    #1;
    chk("async_wr_en", 32'(bus.wr_en), 0);
    chk("async_ack", 32'(bus.ack), 0);
    chk("async_grant_id", 32'(bus.grant_id), 0);
    m_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.req = 4'b0011;
    step();
    chk("post_rst_first", obs_idx, 0);
    step();

`ifdef FIFO_ARB_STALL_CNT_EN
    // Stall counter: exact count then saturation.
    rst = 1'b0;
    m_reset();
    bus.lleno = 1'b1;
    bus.req = 4'b0101;
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("stall5", 32'(stall_cnt), 5);
    repeat (70000) @(posedge clk);
    #1 chk("stall_sat", 32'(stall_cnt), 32'hFFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the single write port of the team's synchronous FIFO (lleno/vacio/use_dw/wr_en/data_in) between NREQ producers.
- Round-robin arbitration with bounded burst ownership.
- Throttles on FIFO occupancy so no write is ever issued into a full FIFO.
- Sits between producer blocks and the FIFO duv port; the read side is untouched.

Parameters:
- NREQ, 4, number of requesters (2..16).
- DEPTH, 32, FIFO depth; must match the FIFO instance.
- WIDTH, 8, data word width.
- MAX_BURST, 4, maximum consecutive grants to one owner (>=1).
- localparam ADDRESS = $clog2(DEPTH-1), width of use_dw. localparam IDW = $clog2(NREQ).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- req  input  NREQ  req[i]=1: requester i has a word on its data slice.
- req_data  input  NREQ*WIDTH  requester i word in bits [i*WIDTH +: WIDTH].
- ack  output  NREQ  combinational grant; word i is consumed at this rising edge.
- lleno  input  1  FIFO full.
- use_dw  input  ADDRESS  FIFO occupancy.
- wr_en  output  1  registered FIFO write enable.
- data_in  output  WIDTH  registered FIFO write data.
- grant_id  output  IDW  registered index of the requester written by the current wr_en.

Behaviour:
- Reset (rst=0, asynchronous):
  - wr_en=0, data_in=0, grant_id=0.
  - State IDLE, burst_cnt=0, last=NREQ-1, so requester 0 has top priority.
  - ack forced to 0 while rst=0.
- Space check, evaluated each cycle in ADDRESS+1 bits: space_ok = !lleno && (use_dw + wr_en) <= DEPTH-2. The wr_en term accounts for the write in flight that is not yet in use_dw.
- At most one ack bit is high per cycle. ack[i] may be high only if req[i]=1 and space_ok=1.
- Handshake is valid/ready:
  - Requesters hold req and data stable until they see ack.
  - req must not depend combinationally on ack.
  - On the edge where ack[i]=1: wr_en<=1, data_in<=req_data[i], grant_id<=i.
  - With no ack: wr_en<=0, and data_in and grant_id hold.
- Latency: word accepted at edge E appears on wr_en/data_in during the following cycle. Throughput is 1 word/cycle.
- FSM states: IDLE, BURST(owner, burst_cnt).
- IDLE:
  - Round-robin search starting at last+1 (mod NREQ).
  - First requesting index is granted: state becomes BURST, owner=i, burst_cnt=1, last=i.
- BURST:
  - If req[owner]=1 and burst_cnt<MAX_BURST: grant owner, burst_cnt+1.
  - If req[owner]=1 and burst_cnt=MAX_BURST:
    - Round-robin search from owner+1, excluding owner. If found, grant the new owner with burst_cnt=1.
    - Otherwise regrant the owner and restart with burst_cnt=1.
  - If req[owner]=0: round-robin search from owner+1. Grant goes to BURST with the new owner; no request goes to IDLE.
- Throttled cycle (space_ok=0): no ack, wr_en<=0. State, owner, burst_cnt and last are all held.
- Simultaneous requests resolve by round-robin order only; no index has fixed priority except out of reset.
- Reset asserted mid-burst:
  - Outputs clear immediately.
  - A word acked at a prior edge but not yet written is dropped. This is acceptable; producers are reset together.
- MAX_BURST=1 degenerates to pure per-word round-robin.

Optional Feature:
- Macro FIFO_ARB_STALL_CNT_EN.
- When defined, an extra output stall_cnt (16 bits, registered) is added. It increments each cycle where |req=1 and space_ok=0, saturates at 16'hFFFF, and resets to 0.
- When undefined, the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset → all requesters then high, FIFO empty: ack order 0,0,0,0,1,1,1,1,2,... (MAX_BURST=4). wr_en high every cycle from the cycle after the first ack; grant_id follows.
- Only req[2] held high for 10 cycles → 10 consecutive acks to 2 (burst restarts at 4). data_in matches each word one cycle later.
- req[1] drops after 2 words while req[3] is pending → next ack goes to 3 in the same cycle req[1] is low, with no idle cycle.
- use_dw=30 and wr_en=1 → ack=0 for that cycle. When use_dw=29 and wr_en=0, grant resumes. With lleno=1, no ack regardless of use_dw. Total writes never exceed DEPTH without reads.
- rst pulsed low mid-burst of owner 1 → wr_en=0 asynchronously. After release, the first grant goes to requester 0 if it is requesting.
- FIFO_ARB_STALL_CNT_EN defined: hold lleno=1 with req=4'b0101 for 5 cycles → stall_cnt=5. Forced stall for 70000 cycles → stall_cnt=16'hFFFF.
